// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with handshake-loaded ratio
// Optional CLK_DIV_PROG_CNT_EN adds a 16-bit free-running tick counter output tick_cnt.
module clk_div_prog #(
    parameter int W       = 8,
    parameter int DEF_DIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         div_err,
    output logic [W-1:0] div_cur,
    output logic         div_out,
`ifdef CLK_DIV_PROG_CNT_EN
    output logic         tick,
    output logic [15:0]  tick_cnt
`else
    output logic         tick
`endif
);

    localparam logic [W-1:0] DEF_N  = W'(DEF_DIV);
    localparam logic [W-1:0] DEF_M1 = W'(DEF_DIV - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] pend_div;
    logic         pend;

    logic         wrap;
    logic         accept;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] cur_nxt;
    logic [W-1:0] high_nxt;

    assign div_ready = ~pend;
    assign accept    = div_valid & div_ready;

    always_comb begin
        wrap     = en & (cnt == div_cur - W'(1));
        cnt_nxt  = cnt;
        cur_nxt  = div_cur;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + W'(1);
        end
        // A request accepted on this same edge leaves pend low, so it cannot swap yet.
        if (wrap && pend) begin
            cur_nxt = pend_div;
        end
        // ceil(N/2) written so N = 2^W-1 cannot overflow.
        high_nxt = (cur_nxt >> 1) + {{(W-1){1'b0}}, cur_nxt[0]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= DEF_M1;
            div_cur  <= DEF_N;
            div_out  <= 1'b0;
            tick     <= 1'b0;
            div_err  <= 1'b0;
            pend     <= 1'b0;
            pend_div <= DEF_N;
        end else begin
            cnt     <= cnt_nxt;
            div_cur <= cur_nxt;
            div_out <= (cnt_nxt < high_nxt);
            tick    <= wrap;
            div_err <= accept && (div_in == '0);
            if (accept && (div_in != '0)) begin
                pend     <= 1'b1;
                pend_div <= div_in;
            end else if (wrap && pend) begin
                pend <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_PROG_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (wrap) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end
`endif

endmodule
